// File: rtl/debounce_pkg.sv
// Shared types and constants for the switch debouncer.
//   state_t                 : 2-bit debounce FSM state encoding
//   DEFAULT_DEBOUNCE_CYCLES : 1 ms qualification window at 50 MHz
//   STATS_W                 : width of the optional aborted-transition counter
package debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW  = 2'b00,
    S_RISE = 2'b01,
    S_HIGH = 2'b10,
    S_FALL = 2'b11
  } state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
  localparam int STATS_W                 = 16;

endpackage

// File: rtl/switch_debouncer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Reusable for any asynchronous level input.
// Ports:
//   clk   : destination clock
//   rst_n : synchronous active-low reset; both flops load RESET_VAL
//   d     : asynchronous input
//   q     : synchronized output (two clk edges of latency)
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic sync1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= RESET_VAL;
      q     <= RESET_VAL;
    end else begin
      sync1 <= d;
      q     <= sync1;
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// Switch / pushbutton debouncer.
// A raw bouncing input is synchronized by sync_2ff, then a 4-state FSM
// requires DEBOUNCE_CYCLES consecutive samples at the new level before the
// clean level d_out changes. Any return to the old level restarts the count.
// Optional build macro: SWITCH_DEBOUNCER_STATS_EN adds bounce_cnt, a
// saturating count of aborted transitions.
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : synchronous active-low reset
//   sw_in      : raw asynchronous switch input
//   d_out      : debounced level (feeds downstream d input)
//   rise       : one-cycle strobe, first cycle d_out shows 1
//   fall       : one-cycle strobe, first cycle d_out shows 0
//   bounce_cnt : aborted-transition count (SWITCH_DEBOUNCER_STATS_EN only)
module switch_debouncer
  import debounce_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int   CNT_W           = 16,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sw_in,
  output logic               d_out,
  output logic               rise,
`ifdef SWITCH_DEBOUNCER_STATS_EN
  output logic               fall,
  output logic [STATS_W-1:0] bounce_cnt
`else
  output logic               fall
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam state_t           RST_STATE = RESET_LEVEL ? S_HIGH : S_LOW;

  logic             sync2;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rise_nxt, fall_nxt;

  sync_2ff #(.RESET_VAL(RESET_LEVEL)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sw_in),
    .q     (sync2)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RST_STATE;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

  // The first sample at the new level counts as 1, so the commit lands on
  // the DEBOUNCE_CYCLES-th consecutive sample and cnt never passes CNT_LAST.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      S_LOW: begin
        if (sync2) begin
          state_nxt = S_RISE;
          cnt_nxt   = CNT_W'(1);
        end else begin
          cnt_nxt   = '0;
        end
      end
      S_RISE: begin
        if (!sync2) begin
          state_nxt = S_LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_HIGH;
          cnt_nxt   = '0;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (!sync2) begin
          state_nxt = S_FALL;
          cnt_nxt   = CNT_W'(1);
        end else begin
          cnt_nxt   = '0;
        end
      end
      S_FALL: begin
        if (sync2) begin
          state_nxt = S_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_LOW;
          cnt_nxt   = '0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
    endcase
  end

  // S_HIGH and S_FALL share bit 1, so the level is read straight off the
  // state register.
  assign d_out = state[1];

`ifdef SWITCH_DEBOUNCER_STATS_EN
  logic abort;
  assign abort = ((state == S_RISE) && !sync2) || ((state == S_FALL) && sync2);

  always_ff @(posedge clk) begin
    if (!rst_n)
      bounce_cnt <= '0;
    else if (abort && (bounce_cnt != '1))
      bounce_cnt <= bounce_cnt + STATS_W'(1);
  end
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer (DEBOUNCE_CYCLES=4, 60 ns clock).
// Directed table vectors, multi-cycle corner sequences, then randomized
// stimulus, all checked every cycle against a run-length reference model.
module tb_switch_debouncer;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sw_in = 1'b0;
  logic d_out, rise, fall;
`ifdef SWITCH_DEBOUNCER_STATS_EN
  logic [15:0] bounce_cnt;
`endif

  always #30 clk = ~clk;

  switch_debouncer #(.DEBOUNCE_CYCLES(D), .CNT_W(16), .RESET_LEVEL(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_in      (sw_in),
    .d_out      (d_out),
    .rise       (rise),
`ifdef SWITCH_DEBOUNCER_STATS_EN
    .fall       (fall),
    .bounce_cnt (bounce_cnt)
`else
    .fall       (fall)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: the FSM sees sw_in as sampled two edges earlier; the
  // level flips once that delayed input has disagreed with it on D
  // consecutive edges. A disagreement run ended early is a bounce.
  logic m_lvl = 1'b0, m_p1 = 1'b0, m_p2 = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
  int   m_run = 0;
  int   m_bnc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic s);
    if (!r) begin
      m_lvl = 1'b0; m_p1 = 1'b0; m_p2 = 1'b0;
      m_rise = 1'b0; m_fall = 1'b0; m_run = 0; m_bnc = 0;
    end else begin
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (m_p2 != m_lvl) begin
        m_run++;
        if (m_run == D) begin
          m_lvl  = m_p2;
          m_run  = 0;
          m_rise = m_lvl;
          m_fall = !m_lvl;
        end
      end else begin
        if (m_run > 0 && m_bnc < 65535) m_bnc++;
        m_run = 0;
      end
      m_p2 = m_p1;
      m_p1 = s;
    end
  endtask

  // One clock: apply inputs, take the edge, check outputs 1 ns later.
  task automatic cycle(input logic r, input logic s);
    rst_n = r;
    sw_in = s;
    @(posedge clk);
    model_edge(r, s);
    #1;
    chk("d_out_model", 32'(d_out), 32'(m_lvl));
    chk("rise_model",  32'(rise),  32'(m_rise));
    chk("fall_model",  32'(fall),  32'(m_fall));
    chk("strobe_excl", 32'(rise & fall), 32'd0);
`ifdef SWITCH_DEBOUNCER_STATS_EN
    chk("bounce_model", 32'(bounce_cnt), 32'(m_bnc));
`endif
  endtask

  typedef struct {
    logic r;
    logic s;
    logic d;
    logic ri;
    logic fa;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic s, input logic d,
                     input logic ri, input logic fa, input int n);
    vec_t v;
    v.r = r; v.s = s; v.d = d; v.ri = ri; v.fa = fa;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  initial begin
    int rises, rise_at, bnc0, hold;
    logic val, rv;
    logic bp [6];

    // Edge numbers in comments count rising edges from time 0.
    add(0, 1, 0, 0, 0, 2);  // 1-2   reset with sw_in=1
    add(1, 1, 0, 0, 0, 5);  // 3-7   first capture at edge 3
    add(1, 1, 1, 1, 0, 1);  // 8     commit, k+5
    add(1, 1, 1, 0, 0, 1);  // 9
    add(1, 0, 1, 0, 0, 5);  // 10-14 fall captured at edge 10
    add(1, 0, 0, 0, 1, 1);  // 15    commit, fall strobe
    add(1, 0, 0, 0, 0, 1);  // 16
    add(1, 1, 0, 0, 0, 2);  // 17-18 two-cycle glitch
    add(1, 0, 0, 0, 0, 6);  // 19-24 glitch aborted at 21

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].r, tbl[i].s);
      chk($sformatf("vec%0d_d_out", i), 32'(d_out), 32'(tbl[i].d));
      chk($sformatf("vec%0d_rise", i),  32'(rise),  32'(tbl[i].ri));
      chk($sformatf("vec%0d_fall", i),  32'(fall),  32'(tbl[i].fa));
    end
`ifdef SWITCH_DEBOUNCER_STATS_EN
    chk("glitch_bounce_cnt", 32'(bounce_cnt), 32'd1);
`endif

    // Bouncy press: exactly one rise, 5 edges after the last 0->1 capture.
    bp[0] = 1; bp[1] = 0; bp[2] = 1; bp[3] = 1; bp[4] = 0; bp[5] = 1;
    rises = 0; rise_at = -1; bnc0 = m_bnc;
    for (int n = 0; n < 16; n++) begin
      cycle(1'b1, (n < 6) ? bp[n] : 1'b1);
      if (rise) begin
        rises++;
        rise_at = n;
      end
    end
    chk("bouncy_rise_count", 32'(rises), 32'd1);
    chk("bouncy_rise_edge", 32'(rise_at), 32'd10);
    chk("bouncy_d_out", 32'(d_out), 32'd1);
`ifdef SWITCH_DEBOUNCER_STATS_EN
    chk("bouncy_bounce_delta", 32'(bounce_cnt) - 32'(bnc0), 32'd2);
`endif

    // Clean fall back to low, then reset while counting toward a rise.
    for (int n = 0; n < 8; n++) cycle(1'b1, 1'b0);
    chk("fall_d_out", 32'(d_out), 32'd0);
    for (int n = 0; n < 4; n++) cycle(1'b1, 1'b1);  // cnt reaches 2
    cycle(1'b0, 1'b1);
    chk("midwait_rst_d_out", 32'(d_out), 32'd0);
    chk("midwait_rst_rise", 32'(rise), 32'd0);
    rises = 0;
    for (int n = 0; n < 8; n++) begin
      cycle(1'b1, 1'b0);
      if (rise) rises++;
    end
    chk("midwait_no_rise", 32'(rises), 32'd0);
    chk("midwait_d_out", 32'(d_out), 32'd0);

    // Randomized runs of varying length with occasional resets.
    val = 1'b0;
    hold = 0;
    for (int n = 0; n < 3000; n++) begin
      if (hold == 0) begin
        val  = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 7);
      end
      hold--;
      rv = ($urandom_range(0, 199) != 0);
      cycle(rv, val);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Conditions a raw, asynchronous, bouncing slide-switch or pushbutton input into a clean, single-clock-domain level `d_out`.
- `d_out` drives the `d` input of the D-latch/flip-flop stage directly downstream.
- Also emits one-cycle rise/fall strobes for downstream edge-driven logic.
- Composition: 2-flop synchronizer, then a 4-state debounce FSM with a stability counter.

Parameters:
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required before `d_out` changes (1 ms at 50 MHz). Legal range 2..2^CNT_W-1.
- `CNT_W`, default 16: stability counter width.
- `RESET_LEVEL`, default 1'b0: value of `d_out` and of both synchronizer flops in reset.

Ports:
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst_n`  input  1  synchronous, active-low reset, sampled on rising `clk`.
- `sw_in`  input  1  raw asynchronous switch/button input.
- `d_out`  output  1  debounced level; feeds downstream `d`.
- `rise`  output  1  one-cycle strobe when `d_out` goes 0->1.
- `fall`  output  1  one-cycle strobe when `d_out` goes 1->0.
- `bounce_cnt`  output  16  aborted-transition count; present only with `SWITCH_DEBOUNCER_STATS_EN`.

Behaviour:
- Reset (`rst_n`=0 at a rising edge):
  - `sync1`, `sync2` and `d_out` <= `RESET_LEVEL`.
  - `rise`, `fall` <= 0; counter <= 0.
  - State <= `S_LOW` if `RESET_LEVEL`=0, else `S_HIGH`.
  - Reset mid-WAIT discards the pending transition; no strobe is issued.
- Synchronizer: `sync1` <= `sw_in`; `sync2` <= `sync1`. The FSM sees `sync2` only.
- States: `S_LOW`, `S_RISE`, `S_HIGH`, `S_FALL`. `d_out` is 1 exactly in `S_HIGH` and `S_FALL` (registered).
- `S_LOW`:
  - `sync2`=1 -> `S_RISE`, cnt <= 1.
  - Otherwise stay, cnt <= 0.
- `S_RISE`:
  - `sync2`=0 -> `S_LOW`, cnt <= 0 (aborted bounce).
  - `sync2`=1 and cnt=`DEBOUNCE_CYCLES`-1 -> `S_HIGH`, cnt <= 0, `rise` <= 1.
  - Otherwise cnt <= cnt+1.
- `S_HIGH` / `S_FALL`: mirror of `S_LOW` / `S_RISE` with polarity swapped; the commit asserts `fall`.
- Strobes: `rise`/`fall` are high for exactly the one cycle in which `d_out` first shows its new value. They are never both high.
- Latency:
  - `sw_in` changes and is first captured at edge k, then stays constant.
  - `d_out` changes at edge k+1+`DEBOUNCE_CYCLES`.
- Glitch rejection: any return of `sync2` to the current `d_out` level before the count completes fully restarts qualification. There is no partial credit.
- Counter: compares against `DEBOUNCE_CYCLES`-1 truncated to `CNT_W`. It never wraps, because the commit occurs before overflow.

Optional Feature:
- Macro: `SWITCH_DEBOUNCER_STATS_EN`.
- Defined:
  - Adds port `bounce_cnt[15:0]`, reset 0.
  - Increments by 1 on every `S_RISE`->`S_LOW` or `S_FALL`->`S_HIGH` abort.
  - Saturates at 16'hFFFF.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package `debounce_pkg`:
  - 2-bit state typedef: `S_LOW`=2'b00, `S_RISE`=2'b01, `S_HIGH`=2'b10, `S_FALL`=2'b11.
  - Constant `DEFAULT_DEBOUNCE_CYCLES`=50000.
  - Constant `STATS_W`=16.
- Sub-module `sync_2ff`: two-flop synchronizer with `clk`, `rst_n`, parameterised reset value; reused for other asynchronous inputs.

Test Plan:
All scenarios use `DEBOUNCE_CYCLES`=4, `clk` period 60 ns, `RESET_LEVEL`=0.
- Reset: hold `rst_n`=0 for 2 cycles with `sw_in`=1 -> `d_out`=0, `rise`=0, `fall`=0, `bounce_cnt`=0; after release, `d_out`=1 at the 6th edge (k+5).
- Clean rise: `sw_in` 0->1 captured at edge 10, held -> `d_out`=1 after edge 15; `rise`=1 only between edges 15 and 16; `fall` stays 0.
- Glitch: `sw_in`=1 for 2 cycles, then 0 -> `d_out` stays 0, no strobes, `bounce_cnt`=1 (stats build).
- Bouncy press: pattern 1,0,1,1,0,1 then steady 1 -> exactly one `rise`, 5 cycles after the last 0->1 capture; `bounce_cnt`=2.
- Clean fall from high: `sw_in` 1->0 captured at edge 30 -> `d_out`=0 after edge 35, one-cycle `fall`.
- Reset mid-WAIT: assert `rst_n`=0 while in `S_RISE` with cnt=2 -> next edge `d_out`=0, counter 0, no `rise` issued.
